// File: rtl/alu_core.sv
// alu_core: registered 32-bit ALU for the single-operand lab datapath.
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset (res=0, zero=1, overflow=0)
//   num1     : 8-bit operand A source, sign-extended to 32 bits
//   op       : 3-bit operation select (add/sub/and/or/not/slt, 110/111 reserved)
//   res      : registered 32-bit result
//   zero     : registered flag, set when the value loaded into res is 0
//   overflow : registered signed-overflow flag for add/sub, 0 otherwise
module alu_core #(
  parameter logic [31:0] B_VAL = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  num1,
  input  logic [2:0]  op,
  output logic [31:0] res,
  output logic        zero,
  output logic        overflow
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_NOT = 3'b100,
    OP_SLT = 3'b101
  } op_e;

  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] nxt_res;
  logic        nxt_ovf;

  assign a = {{24{num1[7]}}, num1};
  assign b = B_VAL;

  always_comb begin
    nxt_res = '0;
    nxt_ovf = 1'b0;
    case (op_e'(op))
      OP_ADD: begin
        nxt_res = a + b;
        nxt_ovf = (a[31] == b[31]) && (nxt_res[31] != a[31]);
      end
      OP_SUB: begin
        nxt_res = a - b;
        nxt_ovf = (a[31] != b[31]) && (nxt_res[31] != a[31]);
      end
      OP_AND:  nxt_res = a & b;
      OP_OR:   nxt_res = a | b;
      OP_NOT:  nxt_res = ~a;
      OP_SLT:  nxt_res = ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
      default: begin
        nxt_res = '0;
        nxt_ovf = 1'b0;
      end
    endcase
  end

  // zero is derived from the same next value loaded into res so both stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res      <= '0;
      zero     <= 1'b1;
      overflow <= 1'b0;
    end else begin
      res      <= nxt_res;
      zero     <= (nxt_res == '0);
      overflow <= nxt_ovf;
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: scoreboard bench for alu_core. Two instances share inputs:
// u_def uses the default B_VAL=1, u_big uses B_VAL=32'h7FFFFFFF. Each issued
// vector pushes an expectation tagged with the instance it targets; a monitor
// pops one entry per rising edge and compares.
module tb_alu_core;

  logic        clk;
  logic        rst_n;
  logic [7:0]  num1;
  logic [2:0]  op;
  logic [31:0] res_d, res_b;
  logic        zero_d, zero_b;
  logic        ovf_d, ovf_b;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          sel;   // 1 = u_def, 2 = u_big
    logic [31:0] r;
    logic        o;
    string       name;
  } exp_t;

  exp_t q[$];

  alu_core u_def (
    .clk(clk), .rst_n(rst_n), .num1(num1), .op(op),
    .res(res_d), .zero(zero_d), .overflow(ovf_d)
  );

  alu_core #(.B_VAL(32'h7FFF_FFFF)) u_big (
    .clk(clk), .rst_n(rst_n), .num1(num1), .op(op),
    .res(res_b), .zero(zero_b), .overflow(ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input int sel, input logic [2:0] o, input logic [7:0] n,
                       input logic [31:0] r, input logic ov, input string name);
    exp_t e;
    @(negedge clk);
    op   = o;
    num1 = n;
    e.sel = sel; e.r = r; e.o = ov; e.name = name;
    q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
      q.delete();
    end
  endtask

  // Monitor: the ALU presents a new result after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        if (e.sel == 1) begin
          chk({e.name, "_res"},  res_d, e.r);
          chk({e.name, "_zero"}, {31'b0, zero_d}, {31'b0, e.r == 32'h0});
          chk({e.name, "_ovf"},  {31'b0, ovf_d},  {31'b0, e.o});
        end else begin
          chk({e.name, "_res"},  res_b, e.r);
          chk({e.name, "_zero"}, {31'b0, zero_b}, {31'b0, e.r == 32'h0});
          chk({e.name, "_ovf"},  {31'b0, ovf_b},  {31'b0, e.o});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    num1  = 8'd2;
    op    = 3'b000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_res",  res_d, 32'h0);
    chk("rst_zero", {31'b0, zero_d}, 32'h1);
    chk("rst_ovf",  {31'b0, ovf_d},  32'h0);
    chk("rst_res_big", res_b, 32'h0);
    rst_n = 1'b1;

    // Main function, B_VAL = 1
    issue(1, 3'b000, 8'd2,   32'h0000_0003, 1'b0, "add");
    issue(1, 3'b001, 8'd255, 32'hFFFF_FFFE, 1'b0, "sub");
    issue(1, 3'b010, 8'd254, 32'h0000_0000, 1'b0, "and");
    issue(1, 3'b011, 8'd170, 32'hFFFF_FFAB, 1'b0, "or");
    issue(1, 3'b100, 8'd240, 32'h0000_000F, 1'b0, "not");
    issue(1, 3'b101, 8'd129, 32'h0000_0001, 1'b0, "slt_neg");
    // SLT boundaries
    issue(1, 3'b101, 8'd1,   32'h0000_0000, 1'b0, "slt_eq");
    issue(1, 3'b101, 8'd0,   32'h0000_0001, 1'b0, "slt_zero");
    issue(1, 3'b101, 8'd127, 32'h0000_0000, 1'b0, "slt_max");
    // Reserved opcodes
    issue(1, 3'b110, 8'hFF,  32'h0000_0000, 1'b0, "rsv6");
    issue(1, 3'b111, 8'hFF,  32'h0000_0000, 1'b0, "rsv7");
    // Overflow, B_VAL = 32'h7FFFFFFF
    issue(2, 3'b000, 8'd1,   32'h8000_0000, 1'b1, "ovf_add");
    issue(2, 3'b001, 8'h80,  32'h7FFF_FF81, 1'b1, "ovf_sub");
    issue(2, 3'b000, 8'hFF,  32'h7FFF_FFFE, 1'b0, "noovf_add");
    drain();

    // Latency: an input change mid-cycle must not reach res before the next edge.
    issue(1, 3'b000, 8'd2, 32'h0000_0003, 1'b0, "lat_a");
    @(posedge clk);
    #3;
    op   = 3'b011;
    num1 = 8'd170;
    #1;
    chk("lat_hold_mid", res_d, 32'h0000_0003);
    issue(1, 3'b011, 8'd170, 32'hFFFF_FFAB, 1'b0, "lat_b");
    // Hold inputs constant: result stays put.
    issue(1, 3'b011, 8'd170, 32'hFFFF_FFAB, 1'b0, "hold1");
    issue(1, 3'b011, 8'd170, 32'hFFFF_FFAB, 1'b0, "hold2");
    issue(1, 3'b011, 8'd170, 32'hFFFF_FFAB, 1'b0, "hold3");
    drain();

    // Asynchronous reset mid-cycle with a nonzero result held.
    issue(1, 3'b000, 8'd2, 32'h0000_0003, 1'b0, "pre_arst");
    drain();
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_res",  res_d, 32'h0);
    chk("arst_zero", {31'b0, zero_d}, 32'h1);
    chk("arst_ovf",  {31'b0, ovf_d},  32'h0);
    @(posedge clk);
    #1;
    chk("arst_hold_res", res_d, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(1, 3'b000, 8'd2, 32'h0000_0003, 1'b0, "post_arst");
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
